mp3_sci_config: RTL and testbench

- Brings the VS1003 decoder out of hardware reset and writes its control registers over the SCI (command) SPI port before any audio data is streamed.
- Sits directly upstream of the MP3 streaming block. Its CONFIG_DONE output drives that block's START. The streaming block owns XDCS/SDI; this block owns XCS, XRESET and the command SPI lines.
- Also services runtime volume-change requests after configuration completes.

---
 rtl/mp3_pkg.sv | 32 +++
 rtl/spi_shift32.sv | 58 +++++
 rtl/mp3_sci_config.sv | 164 ++++++++++++++++
 tb/tb_mp3_sci_config.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// Shared definitions for the VS1003 command (SCI) path: opcodes, register
// addresses, controller state encoding and the frame builder.
package mp3_pkg;

    localparam logic [7:0] SCI_WRITE  = 8'h02;
    localparam logic [7:0] SCI_READ   = 8'h03;

    localparam logic [3:0] SCI_MODE   = 4'h0;
    localparam logic [3:0] SCI_CLOCKF = 4'h3;
    localparam logic [3:0] SCI_VOL    = 4'hB;

    // Index of the runtime volume frame in the write table
    localparam logic [1:0] IDX_VOL_RUNTIME = 2'd3;

    typedef enum logic [2:0] {
        ST_HOLD_RST,
        ST_WAIT_BOOT,
        ST_LOAD,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP,
        ST_READY
    } sci_state_t;

    // Builds a 32-bit SCI write frame: opcode, 8-bit address, 16-bit data
    function automatic logic [31:0] make_write_frame(input logic [3:0]  addr,
                                                     input logic [15:0] data);
        return {SCI_WRITE, 4'h0, addr, data};
    endfunction

endpackage

// File: rtl/spi_shift32.sv
// Tick-driven 32-bit MSB-first SPI mode-0 shifter. Load and start are only
// acted on when i_tick is high; SCLK idles low and every bit takes two ticks
// (rise, then fall with the next bit shifted out). Chip select is left to the
// caller so the shifter can be shared by other command ports.
module spi_shift32 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_start,
    output logic        o_sclk,
    output logic        o_si,
    output logic        o_done
);

    logic [31:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic        r_sclk;
    logic        r_active;

    // Done marks the tick that produces the 32nd falling edge
    assign o_done = i_tick & r_active & r_sclk & (r_bit_cnt == 5'd31);
    assign o_sclk = r_sclk;
    assign o_si   = r_shift[31];

    // Shift register, SCLK phase and bit counter
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_active  <= 1'b0;
        end else if (i_tick) begin
            if (r_active) begin
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else begin
                    r_sclk <= 1'b0;
                    if (r_bit_cnt == 5'd31) begin
                        r_active <= 1'b0;
                    end else begin
                        r_shift   <= {r_shift[30:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
            end else if (i_start) begin
                r_active  <= 1'b1;
                r_sclk    <= 1'b1;
                r_bit_cnt <= '0;
            end else if (i_load) begin
                r_shift <= i_data;
            end
        end
    end

endmodule

// File: rtl/mp3_sci_config.sv
// VS1003 bring-up controller: holds XRESET_n, waits for DREQ, writes MODE,
// CLOCKF and VOL over SCI, then services runtime volume-change requests.
module mp3_sci_config
    import mp3_pkg::*;
#(
    parameter int          CLK_DIV     = 50,
    parameter int          RST_CYCLES  = 100000,
    parameter logic [15:0] MODE_VAL    = 16'h0804,
    parameter logic [15:0] CLOCKF_VAL  = 16'h9800,
    parameter logic [15:0] VOL_DEFAULT = 16'h2020
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        DREQ,
    input  logic        VOL_REQ,
    input  logic [15:0] VOL_VALUE,
    output logic        SCI_SCLK,
    output logic        SCI_SI,
    output logic        SCI_CS_n,
    output logic        XRESET_n,
    output logic        CONFIG_DONE,
    output logic        BUSY
);

    sci_state_t  r_state;
    sci_state_t  w_state_nxt;
    logic [31:0] r_div_cnt;
    logic [31:0] r_rst_cnt;
    logic        r_dreq_meta;
    logic        r_dreq_sync;
    logic [1:0]  r_idx;
    logic [1:0]  r_gap_cnt;
    logic        r_cs_n;
    logic        r_config_done;
    logic [15:0] r_vol_reg;
    logic        r_pending_vol;
    logic        w_tick;
    logic        w_load;
    logic        w_start;
    logic        w_shift_done;
    logic [31:0] w_frame;

    assign w_tick      = (r_div_cnt == 32'(CLK_DIV - 1));
    assign SCI_CS_n    = r_cs_n;
    assign XRESET_n    = (r_state != ST_HOLD_RST);
    assign CONFIG_DONE = r_config_done;
    assign BUSY        = (r_state != ST_READY);

    // SCLK half-period tick generator
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_div_cnt <= '0;
        else       r_div_cnt <= w_tick ? '0 : r_div_cnt + 32'd1;
    end

    // Two-flop synchroniser for the asynchronous DREQ pin
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_dreq_meta <= 1'b0;
            r_dreq_sync <= 1'b0;
        end else begin
            r_dreq_meta <= DREQ;
            r_dreq_sync <= r_dreq_meta;
        end
    end

    // Controller state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_HOLD_RST;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic and shifter handshakes
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_HOLD_RST:  if (r_rst_cnt == 32'(RST_CYCLES - 1)) w_state_nxt = ST_WAIT_BOOT;
            ST_WAIT_BOOT: if (r_dreq_sync) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (w_tick) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (w_tick) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT:     if (w_shift_done) w_state_nxt = ST_CS_HOLD;
            ST_CS_HOLD:   if (w_tick) w_state_nxt = ST_GAP;
            ST_GAP: begin
                if (r_gap_cnt == 2'd2 && r_dreq_sync)
                    w_state_nxt = (r_idx < 2'd2) ? ST_LOAD : ST_READY;
            end
            ST_READY:     if (r_pending_vol && r_dreq_sync) w_state_nxt = ST_LOAD;
            default:      w_state_nxt = ST_HOLD_RST;
        endcase
    end

    // Write-table lookup for the frame about to be loaded
    always_comb begin
        w_frame = make_write_frame(SCI_VOL, r_vol_reg);
        case (r_idx)
            2'd0:    w_frame = make_write_frame(SCI_MODE, MODE_VAL);
            2'd1:    w_frame = make_write_frame(SCI_CLOCKF, CLOCKF_VAL);
            2'd2:    w_frame = make_write_frame(SCI_VOL, VOL_DEFAULT);
            default: w_frame = make_write_frame(SCI_VOL, r_vol_reg);
        endcase
    end

    // Sequencing counters, chip select and the sticky done flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rst_cnt     <= '0;
            r_idx         <= '0;
            r_gap_cnt     <= '0;
            r_cs_n        <= 1'b1;
            r_config_done <= 1'b0;
        end else begin
            if (r_state == ST_HOLD_RST) r_rst_cnt <= r_rst_cnt + 32'd1;

            if (r_state != ST_GAP)                   r_gap_cnt <= '0;
            else if (w_tick && r_gap_cnt != 2'd2)    r_gap_cnt <= r_gap_cnt + 2'd1;

            if (r_state == ST_GAP && w_state_nxt == ST_LOAD)   r_idx <= r_idx + 2'd1;
            if (r_state == ST_READY && w_state_nxt == ST_LOAD) r_idx <= IDX_VOL_RUNTIME;

            // CS is low from the load tick through the hold tick
            r_cs_n <= !(w_state_nxt inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});

            if (w_state_nxt == ST_READY) r_config_done <= 1'b1;
        end
    end

    // Volume request capture; a new request in the load cycle wins over the clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_vol_reg     <= '0;
            r_pending_vol <= 1'b0;
        end else if (VOL_REQ) begin
            r_vol_reg     <= VOL_VALUE;
            r_pending_vol <= 1'b1;
        end else if (w_load && r_idx == IDX_VOL_RUNTIME) begin
            r_pending_vol <= 1'b0;
        end
    end

    spi_shift32 u_shift (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_tick  (w_tick),
        .i_load  (w_load),
        .i_data  (w_frame),
        .i_start (w_start),
        .o_sclk  (SCI_SCLK),
        .o_si    (SCI_SI),
        .o_done  (w_shift_done)
    );

endmodule

// File: tb/tb_mp3_sci_config.sv
// Directed bench for mp3_sci_config: decodes SCI frames from the pins and
// compares them, plus CS/XRESET/DONE/BUSY timing, against hand-computed values.
module tb_mp3_sci_config;

    localparam int CLK_DIV    = 2;
    localparam int RST_CYCLES = 20;
    localparam int TICK_T     = CLK_DIV * 10;

    logic        CLK       = 1'b0;
    logic        RESET     = 1'b1;
    logic        DREQ      = 1'b1;
    logic        VOL_REQ   = 1'b0;
    logic [15:0] VOL_VALUE = 16'h0000;
    logic        SCI_SCLK, SCI_SI, SCI_CS_n, XRESET_n, CONFIG_DONE, BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] frames[$];
    int          bits_q[$];
    longint      setup_q[$], hold_q[$], gap_q[$];
    logic [31:0] mon_shift = '0;
    int          mon_bits  = 0;
    longint      t_cs_fall = 0, t_first_rise = 0, t_last_fall = 0, t_cs_rise = -1;

    always #5 CLK = ~CLK;

    mp3_sci_config #(
        .CLK_DIV    (CLK_DIV),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DREQ        (DREQ),
        .VOL_REQ     (VOL_REQ),
        .VOL_VALUE   (VOL_VALUE),
        .SCI_SCLK    (SCI_SCLK),
        .SCI_SI      (SCI_SI),
        .SCI_CS_n    (SCI_CS_n),
        .XRESET_n    (XRESET_n),
        .CONFIG_DONE (CONFIG_DONE),
        .BUSY        (BUSY)
    );

    // Pin-level SCI frame monitor
    always @(negedge SCI_CS_n) begin
        mon_shift = '0;
        mon_bits  = 0;
        t_cs_fall = $time;
        if (t_cs_rise >= 0) gap_q.push_back($time - t_cs_rise);
    end

    always @(posedge SCI_SCLK) begin
        if (SCI_CS_n === 1'b0) begin
            if (mon_bits == 0) t_first_rise = $time;
            mon_shift = {mon_shift[30:0], SCI_SI};
            mon_bits++;
        end
    end

    always @(negedge SCI_SCLK) t_last_fall = $time;

    always @(posedge SCI_CS_n) begin
        if (RESET !== 1'b0) begin
            t_cs_rise = -1;
        end else begin
            frames.push_back(mon_shift);
            bits_q.push_back(mon_bits);
            setup_q.push_back(t_first_rise - t_cs_fall);
            hold_q.push_back($time - t_last_fall);
            t_cs_rise = $time;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame_at(input int i);
        if (i < frames.size()) return frames[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int bits_at(input int i);
        if (i < bits_q.size()) return bits_q[i];
        return -1;
    endfunction

    task automatic check_init(input int base, input string tag);
        logic [31:0] exp_f [3] = '{32'h0200_0804, 32'h0203_9800, 32'h020B_2020};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_frame%0d", tag, i), frame_at(base + i), exp_f[i]);
            check($sformatf("%s_bits%0d", tag, i), 32'(bits_at(base + i)), 32'd32);
        end
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while (CONFIG_DONE !== 1'b1 && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_done_seen"}, 32'(CONFIG_DONE === 1'b1), 32'd1);
    endtask

    task automatic wait_cs(input logic level, input int max_cyc, input string tag);
        int n = 0;
        while (SCI_CS_n !== level && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(SCI_CS_n === level), 32'd1);
    endtask

    task automatic wait_frames(input int cnt, input int max_cyc, input string tag);
        int n = 0;
        while (frames.size() < cnt && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(frames.size() >= cnt), 32'd1);
    endtask

    task automatic pulse_vol(input logic [15:0] value);
        VOL_VALUE = value;
        VOL_REQ   = 1'b1;
        @(negedge CLK);
        VOL_REQ   = 1'b0;
    endtask

    task automatic clear_mon;
        frames.delete();
        bits_q.delete();
        setup_q.delete();
        hold_q.delete();
        gap_q.delete();
    endtask

    task automatic apply_reset;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        clear_mon();
        t_cs_rise = -1;
        RESET = 1'b0;
    endtask

    initial begin : main
        int n;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_sclk", 32'(SCI_SCLK), 32'd0);
        check("rst_si", 32'(SCI_SI), 32'd0);
        check("rst_cs_n", 32'(SCI_CS_n), 32'd1);
        check("rst_xreset_n", 32'(XRESET_n), 32'd0);
        check("rst_config_done", 32'(CONFIG_DONE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd1);

        // Power-up with DREQ always high
        RESET = 1'b0;
        n = 0;
        while (XRESET_n !== 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("xreset_low_cycles", 32'(n), 32'(RST_CYCLES));
        wait_done(3000, "pwr");
        check("pwr_busy_falls_with_done", 32'(BUSY), 32'd0);
        check("pwr_done_after_gap", 32'(t_cs_rise >= 0 && ($time - t_cs_rise) >= 2 * TICK_T), 32'd1);
        check_init(0, "pwr");
        check("pwr_frame_count", 32'(frames.size()), 32'd3);
        check("pwr_cs_setup_one_tick", 32'(setup_q.size() > 0 ? setup_q[0] : -1), 32'(TICK_T));
        check("pwr_cs_hold_one_tick", 32'(hold_q.size() > 0 ? hold_q[0] : -1), 32'(TICK_T));
        check("pwr_gap_min_two_ticks", 32'(gap_q.size() > 0 && gap_q[0] >= 2 * TICK_T), 32'd1);

        // DREQ stall after frame 1
        apply_reset();
        wait_frames(1, 2000, "stall_frame1_seen");
        DREQ = 1'b0;
        n = 0;
        repeat (500) begin
            @(negedge CLK);
            if (SCI_CS_n !== 1'b1) n++;
        end
        check("stall_no_cs_activity", 32'(n), 32'd0);
        check("stall_frame_count", 32'(frames.size()), 32'd1);
        check("stall_busy", 32'(BUSY), 32'd1);
        DREQ = 1'b1;
        n = 0;
        while (SCI_CS_n !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("stall_restart_within_3_ticks", 32'(n <= 3 * CLK_DIV), 32'd1);
        wait_done(3000, "stall");
        check_init(0, "stall");

        // Single runtime volume write in READY
        clear_mon();
        repeat (10) @(negedge CLK);
        pulse_vol(16'h4040);
        wait_cs(1'b0, 50, "vol_cs_fall_seen");
        check("vol_busy_in_frame", 32'(BUSY), 32'd1);
        wait_cs(1'b1, 400, "vol_cs_rise_seen");
        check("vol_busy_after_frame", 32'(BUSY), 32'd1);
        n = 0;
        while (BUSY !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("vol_busy_falls", 32'(BUSY), 32'd0);
        repeat (300) @(negedge CLK);
        check("vol_frame_count", 32'(frames.size()), 32'd1);
        check("vol_frame", frame_at(0), 32'h020B_4040);
        check("vol_done_sticky", 32'(CONFIG_DONE), 32'd1);

        // Second request mid-frame: one more frame with the latest value
        clear_mon();
        pulse_vol(16'h1010);
        wait_cs(1'b0, 50, "vol2_cs_fall_seen");
        repeat (30) @(negedge CLK);
        pulse_vol(16'h3030);
        repeat (800) @(negedge CLK);
        check("vol2_frame_count", 32'(frames.size()), 32'd2);
        check("vol2_frame0", frame_at(0), 32'h020B_1010);
        check("vol2_frame1", frame_at(1), 32'h020B_3030);
        check("vol2_idle", 32'(BUSY), 32'd0);

        // Request during HOLD_RST is issued after CONFIG_DONE
        apply_reset();
        repeat (5) @(negedge CLK);
        check("early_in_hold_rst", 32'(XRESET_n), 32'd0);
        pulse_vol(16'h0000);
        wait_done(3000, "early");
        repeat (400) @(negedge CLK);
        check_init(0, "early");
        check("early_frame_count", 32'(frames.size()), 32'd4);
        check("early_vol_frame", frame_at(3), 32'h020B_0000);

        // Reset pulse during bit 17 of frame 2
        apply_reset();
        wait_frames(1, 2000, "abort_frame1_seen");
        n = 0;
        while (!(SCI_CS_n === 1'b0 && mon_bits == 17) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("abort_bit17_reached", 32'(SCI_CS_n === 1'b0 && mon_bits == 17), 32'd1);
        RESET = 1'b1;
        #1;
        check("abort_cs_n", 32'(SCI_CS_n), 32'd1);
        check("abort_xreset_n", 32'(XRESET_n), 32'd0);
        check("abort_config_done", 32'(CONFIG_DONE), 32'd0);
        check("abort_sclk", 32'(SCI_SCLK), 32'd0);
        check("abort_no_partial_frame", 32'(frames.size()), 32'd1);
        repeat (3) @(negedge CLK);
        clear_mon();
        t_cs_rise = -1;
        RESET = 1'b0;
        wait_done(3000, "restart");
        check_init(0, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
